// File: rtl/instrumented_adder_sequencer_pkg.sv
// Shared types and constants for the instrumented adder sequencer.
package instrumented_adder_sequencer_pkg;

  localparam int COUNT_W       = 32;
  localparam int ACCUM_W       = 36;
  localparam int SETTLE_CYCLES = 4;
  localparam int CLEAR_CYCLES  = 2;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CLEAR   = 3'd1,
    ST_LOAD    = 3'd2,
    ST_RUN     = 3'd3,
    ST_SETTLE  = 3'd4,
    ST_CAPTURE = 3'd5
  } state_t;

endpackage

// File: rtl/instrumented_adder_sequencer_sync.sv
// Two-flop synchroniser bringing the adder's done flag into the wb_clk_i domain.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic sync_p0;
  logic sync_p1;

  // Metastability filter: first flop may go metastable, second resolves it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
    end else begin
      sync_p0 <= d;
      sync_p1 <= sync_p0;
    end
  end

  assign q = sync_p1;

endmodule

// File: rtl/instrumented_adder_sequencer.sv
// Sequencer driving a ring-oscillator adder through clear/load/run/settle/capture
// for 1..16 runs, accumulating the ring counts.
// Optional feature: define SEQ_MINMAX_EN to build min/max count tracking;
// without it min_count and max_count are tied to 0.
module instrumented_adder_sequencer
  import instrumented_adder_sequencer_pkg::*;
(
  input  logic        wb_clk_i,
  input  logic        wb_rst_ni,
  input  logic        start,
  input  logic        abort,
  input  logic [31:0] integration_time,
  input  logic [3:0]  num_runs,
  output logic        adder_reset,
  output logic        adder_stop_b,
  output logic        adder_counter_enable,
  output logic        adder_counter_load,
  output logic [31:0] adder_integration_time,
  input  logic        adder_done,
  input  logic [31:0] ring_count,
  output logic        busy,
  output logic        result_valid,
  output logic [31:0] last_count,
  output logic [35:0] accum,
  output logic [31:0] min_count,
  output logic [31:0] max_count
);

  localparam logic [2:0] CLEAR_LAST  = 3'(CLEAR_CYCLES - 1);
  localparam logic [2:0] SETTLE_LAST = 3'(SETTLE_CYCLES - 1);

  state_t               state_q;
  state_t               state_d;
  logic [2:0]           phase_cnt_q;
  logic [3:0]           run_cnt_q;
  logic [3:0]           num_runs_q;
  logic [COUNT_W-1:0]   integ_q;
  logic [COUNT_W-1:0]   last_q;
  logic [ACCUM_W-1:0]   accum_q;
  logic                 valid_q;
  logic                 done_sync;
  logic                 accept_start;
  logic                 capture_en;
  logic                 last_run;

  sync_2ff u_done_sync (
    .clk   (wb_clk_i),
    .rst_n (wb_rst_ni),
    .d     (adder_done),
    .q     (done_sync)
  );

  assign accept_start = (state_q == ST_IDLE) && start && !abort;
  assign capture_en   = (state_q == ST_CAPTURE) && !abort;
  assign last_run     = (run_cnt_q == num_runs_q);

  // State register.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) state_q <= ST_IDLE;
    else            state_q <= state_d;
  end

  // Next-state logic; abort overrides every other event.
  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:    if (start) state_d = ST_CLEAR;
        ST_CLEAR:   if (phase_cnt_q == CLEAR_LAST) state_d = ST_LOAD;
        ST_LOAD:    state_d = ST_RUN;
        ST_RUN:     if (done_sync) state_d = ST_SETTLE;
        ST_SETTLE:  if (phase_cnt_q == SETTLE_LAST) state_d = ST_CAPTURE;
        ST_CAPTURE: state_d = last_run ? ST_IDLE : ST_CLEAR;
        default:    state_d = ST_IDLE;
      endcase
    end
  end

  // Moore outputs decoded from the current state.
  always_comb begin
    adder_reset          = 1'b0;
    adder_stop_b         = 1'b0;
    adder_counter_enable = 1'b0;
    adder_counter_load   = 1'b0;
    case (state_q)
      ST_CLEAR: adder_reset = 1'b1;
      ST_LOAD:  adder_counter_load = 1'b1;
      ST_RUN: begin
        adder_stop_b         = 1'b1;
        adder_counter_enable = 1'b1;
      end
      default: ;
    endcase
  end

  // Dwell counter for the fixed-length CLEAR and SETTLE phases; restarts on every state change.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni)              phase_cnt_q <= '0;
    else if (state_d != state_q) phase_cnt_q <= '0;
    else                         phase_cnt_q <= phase_cnt_q + 3'd1;
  end

  // Job parameters, run counter and result registers.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      integ_q    <= '0;
      num_runs_q <= '0;
      run_cnt_q  <= '0;
      last_q     <= '0;
      accum_q    <= '0;
    end else if (accept_start) begin
      integ_q    <= integration_time;
      num_runs_q <= num_runs;
      run_cnt_q  <= '0;
      last_q     <= '0;
      accum_q    <= '0;
    end else if (capture_en) begin
      last_q  <= ring_count;
      accum_q <= accum_q + {{(ACCUM_W-COUNT_W){1'b0}}, ring_count};
      if (!last_run) run_cnt_q <= run_cnt_q + 4'd1;
    end
  end

  // result_valid: set by the final capture, cleared by abort or an accepted start.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni)                  valid_q <= 1'b0;
    else if (abort || accept_start)  valid_q <= 1'b0;
    else if (capture_en && last_run) valid_q <= 1'b1;
  end

`ifdef SEQ_MINMAX_EN
  logic [COUNT_W-1:0] min_q;
  logic [COUNT_W-1:0] max_q;

  // Extremes across runs; equal counts leave the stored value alone.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      min_q <= '1;
      max_q <= '0;
    end else if (accept_start) begin
      min_q <= '1;
      max_q <= '0;
    end else if (capture_en) begin
      if (ring_count < min_q) min_q <= ring_count;
      if (ring_count > max_q) max_q <= ring_count;
    end
  end

  assign min_count = min_q;
  assign max_count = max_q;
`else
  assign min_count = '0;
  assign max_count = '0;
`endif

  assign busy                   = (state_q != ST_IDLE);
  assign result_valid           = valid_q;
  assign last_count             = last_q;
  assign accum                  = accum_q;
  assign adder_integration_time = integ_q;

endmodule
